// File: rtl/uart_rx_defs_pkg.sv
// Shared definitions for the UART receive peripheral: register offsets,
// STATUS bit positions, receiver FSM encoding and oversampling constants.
package uart_rx_defs;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_TICK   = OVERSAMPLE / 2 - 1;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h2;
    localparam logic [3:0] REG_LEVEL  = 4'h4;
    localparam logic [3:0] REG_CLEAR  = 4'h6;

    localparam int unsigned ST_RX_READY  = 0;
    localparam int unsigned ST_OVERRUN   = 1;
    localparam int unsigned ST_FRAME_ERR = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer. UART_RX_FIFO_EN selects a circular FIFO of DEPTH bytes;
// otherwise a single holding register. Flags and count are registered.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic             do_push_c;
    logic             do_pop_c;
    logic [CNT_W-1:0] count_nxt_c;

    // A pop frees the slot the same cycle, so a push into a full buffer still lands
    assign do_pop_c  = pop & ~empty;
    assign do_push_c = push & (~full | do_pop_c);

`ifdef UART_RX_FIFO_EN
    localparam int unsigned CAP   = DEPTH;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];
`else
    localparam int unsigned CAP = 1;

    logic [7:0] hold_q;

    always_ff @(posedge clk) begin
        if (rst)            hold_q <= '0;
        else if (do_push_c) hold_q <= din;
    end

    assign dout = hold_q;
`endif

    always_comb begin
        count_nxt_c = count;
        if (do_push_c && !do_pop_c)      count_nxt_c = count + CNT_W'(1);
        else if (do_pop_c && !do_push_c) count_nxt_c = count - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            count <= count_nxt_c;
            empty <= (count_nxt_c == '0);
            full  <= (count_nxt_c == CNT_W'(CAP));
        end
    end

endmodule

// File: rtl/peripheral_uart_rx.sv
// 16x-oversampled 8N1 UART receiver with J1 peripheral bus registers.
// Buffer depth is set by UART_RX_FIFO_EN (FIFO) or its absence (one byte).
module peripheral_uart_rx
    import uart_rx_defs::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    input  logic        uart_rx,
    output logic        rx_ready
);

    localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             rx_meta, rx_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick_c;

    rx_state_e        state, state_nxt;
    logic [3:0]       tick_cnt, tick_cnt_nxt;
    logic [2:0]       bit_cnt, bit_cnt_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             armed, armed_nxt;
    logic             push_c, ferr_set_c;

    logic             fifo_full, fifo_empty;
    logic [7:0]       fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic             rd_c, pop_c, clr_c, overrun_set_c;
    logic             overrun, frame_err;
    logic [15:0]      rdata_c;
    logic             unused_c;

    // Two-flop synchronizer, idle-high reset so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick_c = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)         div_cnt <= '0;
        else if (tick_c) div_cnt <= '0;
        else             div_cnt <= div_cnt + DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            armed    <= 1'b0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shift    <= shift_nxt;
            armed    <= armed_nxt;
        end
    end

    // Frame FSM; IDLE only rearms after seeing the line high (break / bad stop)
    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift;
        armed_nxt    = armed;
        push_c       = 1'b0;
        ferr_set_c   = 1'b0;
        if (tick_c) begin
            case (state)
                S_IDLE: begin
                    if (!armed) begin
                        armed_nxt = rx_s;
                    end else if (!rx_s) begin
                        state_nxt    = S_START;
                        tick_cnt_nxt = '0;
                    end
                end
                S_START: begin
                    if (tick_cnt == 4'(MID_TICK)) begin
                        tick_cnt_nxt = '0;
                        bit_cnt_nxt  = '0;
                        state_nxt    = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        tick_cnt_nxt = tick_cnt + 4'd1;
                    end
                end
                S_DATA: begin
                    if (tick_cnt == 4'(OVERSAMPLE - 1)) begin
                        tick_cnt_nxt = '0;
                        shift_nxt    = {rx_s, shift[7:1]};
                        bit_cnt_nxt  = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state_nxt = S_STOP;
                    end else begin
                        tick_cnt_nxt = tick_cnt + 4'd1;
                    end
                end
                S_STOP: begin
                    if (tick_cnt == 4'(OVERSAMPLE - 1)) begin
                        tick_cnt_nxt = '0;
                        state_nxt    = S_IDLE;
                        armed_nxt    = 1'b0;
                        push_c       = rx_s;
                        ferr_set_c   = ~rx_s;
                    end else begin
                        tick_cnt_nxt = tick_cnt + 4'd1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .pop   (pop_c),
        .din   (shift),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rx_ready      = ~fifo_empty;
    assign rd_c          = cs & rd;
    assign pop_c         = rd_c & (addr == REG_DATA) & ~fifo_empty;
    assign clr_c         = cs & wr & (addr == REG_CLEAR);
    assign overrun_set_c = push_c & fifo_full & ~pop_c;
    assign unused_c      = ^d_in[15:2];

    always_comb begin
        rdata_c = '0;
        case (addr)
            REG_DATA:   if (!fifo_empty) rdata_c = {8'h00, fifo_dout};
            REG_STATUS: begin
                rdata_c[ST_RX_READY]  = ~fifo_empty;
                rdata_c[ST_OVERRUN]   = overrun;
                rdata_c[ST_FRAME_ERR] = frame_err;
            end
            REG_LEVEL:  rdata_c = 16'(fifo_count);
            default:    rdata_c = '0;
        endcase
    end

    // Sticky flags: a set in the same cycle as a W1C wins
    always_ff @(posedge clk) begin
        if (rst) begin
            d_out     <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (overrun_set_c)         overrun <= 1'b1;
            else if (clr_c && d_in[0]) overrun <= 1'b0;
            if (ferr_set_c)            frame_err <= 1'b1;
            else if (clr_c && d_in[1]) frame_err <= 1'b0;
            if (rd_c)                  d_out <= rdata_c;
        end
    end

endmodule

// File: tb/tb_peripheral_uart_rx.sv
// Scoreboard bench for peripheral_uart_rx at default clock/baud (432 clocks per bit).
// Bus reads queue their expected value; a monitor checks d_out after each read edge.
`timescale 1ns/1ps
module tb_peripheral_uart_rx;

    localparam int unsigned BIT_CLKS = 432;
`ifdef UART_RX_FIFO_EN
    localparam int unsigned DEPTH = 8;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam logic [3:0] A_DATA   = 4'h0;
    localparam logic [3:0] A_STATUS = 4'h2;
    localparam logic [3:0] A_LEVEL  = 4'h4;
    localparam logic [3:0] A_CLEAR  = 4'h6;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] d_in;
    logic        cs;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_out;
    logic        uart_rx;
    logic        rx_ready;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    peripheral_uart_rx dut (
        .clk      (clk),
        .rst      (rst),
        .d_in     (d_in),
        .cs       (cs),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .d_out    (d_out),
        .uart_rx  (uart_rx),
        .rx_ready (rx_ready)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every bus read sampled on a rising edge is checked at the next falling edge
    initial begin
        forever begin
            @(posedge clk);
            if (cs && rd && !rst) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got %h expected no read", d_out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check(e.name, d_out, e.exp);
                end
            end
        end
    end

    task automatic bus_read(input logic [3:0] a, input logic [15:0] exp, input string name);
        exp_t e;
        e.exp  = exp;
        e.name = name;
        exp_q.push_back(e);
        cs   = 1'b1;
        rd   = 1'b1;
        addr = a;
        @(negedge clk);
        cs = 1'b0;
        rd = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] data);
        cs   = 1'b1;
        wr   = 1'b1;
        addr = a;
        d_in = data;
        @(negedge clk);
        cs   = 1'b0;
        wr   = 1'b0;
        d_in = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        idle(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            idle(BIT_CLKS);
        end
        uart_rx = stop;
        idle(BIT_CLKS);
        uart_rx = 1'b1;
    endtask

    // Pops DATA on exactly the edge where the receiver pushes a byte
    task automatic read_on_push(input logic [15:0] exp, input string name);
        int n;
        n = 0;
        while (!dut.push_c && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (!dut.push_c) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no push expected push within 6000 cycles", name);
        end else begin
            bus_read(A_DATA, exp, name);
        end
    endtask

    // Issues a frame_err W1C on the edge where a new framing error is flagged
    task automatic clear_on_ferr();
        int n;
        n = 0;
        while (!dut.ferr_set_c && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (!dut.ferr_set_c) begin
            checks++;
            errors++;
            $display("FAIL ferr_timeout: got no framing error expected one within 6000 cycles");
        end else begin
            bus_write(A_CLEAR, 16'h0002);
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        cs      = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        d_in    = '0;
        uart_rx = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);

        check("reset_d_out", d_out, 16'h0000);
        check("reset_rx_ready", 16'(rx_ready), 16'h0000);
        bus_read(A_STATUS, 16'h0000, "reset_status");
        bus_read(A_LEVEL, 16'h0000, "reset_level");
        idle(60);

        // Single byte
        send_frame(8'hA5, 1'b1);
        idle(20);
        check("single_rx_ready", 16'(rx_ready), 16'h0001);
        bus_read(A_STATUS, 16'h0001, "single_status");
        bus_read(A_DATA, 16'h00A5, "single_data");
        idle(2);
        bus_read(A_LEVEL, 16'h0000, "single_level_after");
        check("single_rx_ready_after", 16'(rx_ready), 16'h0000);
        bus_read(A_DATA, 16'h0000, "empty_data");

        // Glitch rejection
        uart_rx = 1'b0;
        idle(100);
        uart_rx = 1'b1;
        idle(400);
        bus_read(A_LEVEL, 16'h0000, "glitch_level");
        bus_read(A_STATUS, 16'h0000, "glitch_status");
        send_frame(8'h3C, 1'b1);
        idle(20);
        bus_read(A_DATA, 16'h003C, "glitch_next_data");

        // Framing error
        idle(50);
        send_frame(8'h55, 1'b0);
        idle(450);
        bus_read(A_STATUS, 16'h0004, "ferr_status");
        bus_read(A_LEVEL, 16'h0000, "ferr_level");
        bus_write(A_CLEAR, 16'h0002);
        bus_read(A_STATUS, 16'h0000, "ferr_cleared");

        // Framing error coinciding with its W1C
        idle(100);
        fork
            send_frame(8'h55, 1'b0);
            clear_on_ferr();
        join
        idle(20);
        bus_read(A_STATUS, 16'h0004, "ferr_set_wins");
        bus_write(A_CLEAR, 16'h0002);
        bus_read(A_STATUS, 16'h0000, "ferr_cleared2");
        idle(100);

        // Overflow: one byte more than capacity
        for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 1'b1);
        idle(20);
        bus_read(A_LEVEL, 16'(DEPTH), "ovf_level");
        bus_read(A_STATUS, 16'h0003, "ovf_status");
        bus_write(A_CLEAR, 16'h0001);
        bus_read(A_STATUS, 16'h0001, "ovf_cleared");
        idle(50);

        // Push and pop on the same edge while full
        fork
            send_frame(8'h5A, 1'b1);
            read_on_push(16'h0001, "simul_pop_data");
        join
        idle(20);
        bus_read(A_STATUS, 16'h0001, "simul_no_overrun");
        bus_read(A_LEVEL, 16'(DEPTH), "simul_level");
        for (int i = 2; i <= DEPTH; i++) bus_read(A_DATA, 16'(i), "drain_data");
        bus_read(A_LEVEL, 16'h0001, "drain_level");
        bus_read(A_STATUS, 16'h0001, "pre_reset_status");
        idle(50);

        // Reset during data bit 4 of a frame of zeros
        uart_rx = 1'b0;
        idle(5 * BIT_CLKS + 200);
        rst = 1'b1;
        idle(1);
        rst     = 1'b0;
        uart_rx = 1'b1;
        check("midreset_d_out", d_out, 16'h0000);
        check("midreset_rx_ready", 16'(rx_ready), 16'h0000);
        bus_read(A_STATUS, 16'h0000, "midreset_status");
        bus_read(A_LEVEL, 16'h0000, "midreset_level");
        idle(1000);
        bus_read(A_LEVEL, 16'h0000, "midreset_no_push");
        send_frame(8'hC3, 1'b1);
        idle(20);
        bus_read(A_STATUS, 16'h0001, "after_reset_status");
        bus_read(A_DATA, 16'h00C3, "after_reset_data");
        bus_read(4'h8, 16'h0000, "unmapped_read");
        idle(5);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending_reads: got %0d unchecked expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/peripheral_uart_rx.md
# peripheral_uart_rx

Serial UART receiver peripheral for the J1 SoC, the receive-side counterpart of `peripheral_uart`. It oversamples the `uart_rx` line 16x, assembles 8N1 frames and buffers received bytes. The J1 reads the bytes through the standard peripheral bus (`cs`/`rd`/`wr`/`addr`/`d_in`/`d_out`). The top decoder maps it at `j1_io_addr[15:8] = 8'h72`.

## Interface
- `CLK_FREQ`, 50000000: system clock frequency, Hz.
- `BAUD`, 115200: line rate. Oversample divisor `DIV = CLK_FREQ/(BAUD*16)`, integer-truncated; 27 at the defaults.
- `FIFO_DEPTH`, 8: receive buffer depth; power of two, ≥2. Used only with `UART_RX_FIFO_EN`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `d_in`  in  16  write data from J1.
- `cs`  in  1  chip select from the address decoder.
- `addr`  in  4  register offset, `j1_io_addr[3:0]`.
- `rd`  in  1  J1 read strobe.
- `wr`  in  1  J1 write strobe.
- `d_out`  out  16  registered read data.
- `uart_rx`  in  1  asynchronous serial input; idles high.
- `rx_ready`  out  1  high when at least one byte is buffered.

## Operation
- `uart_rx` passes through a 2-flop synchronizer; both flops reset to 1.
- Tick counter: counts 0..DIV-1 and pulses `tick` on wrap.
- The FSM advances only on `tick` and counts 16 ticks per bit.
  - IDLE: armed only after the synced line has been seen high. Synced 0 → START, tick count cleared.
  - START: at tick 7 (mid-bit) the line is resampled. 1 = glitch → IDLE. 0 → DATA.
  - DATA: 8 bits, LSB first. Each bit is sampled 16 ticks after the previous sample point. After bit 7 → STOP.
  - STOP: sampled 16 ticks later. 1 → push the byte. 0 → set `frame_err` and discard the byte. Either way → IDLE, which rearms only once the line is high (covers break conditions).
- Registers, each accessed when `cs` and the strobe are high:
  - 0x0 read DATA: `{8'h00, head}` and pop. If empty, returns 16'h0000 and nothing is popped.
  - 0x2 read STATUS: `{13'b0, frame_err, overrun, rx_ready}`.
  - 0x4 read LEVEL: byte count, zero-extended.
  - 0x6 write CLEAR: W1C. `d_in[0]` clears `overrun`, `d_in[1]` clears `frame_err`.
  - Any other offset reads 16'h0000. Writes to other offsets are ignored.
- Push into a full buffer drops the new byte and sets `overrun`. Buffered contents are preserved.
- Push and pop in the same cycle: both occur and the count is unchanged. This applies when full as well, with no overrun.
- A sticky flag set and W1C-cleared in the same cycle stays set (set wins).

## Timing
- Reset values: `d_out` = 0, `rx_ready` = 0, `overrun` = 0, `frame_err` = 0, count = 0, FSM = IDLE, tick counter = 0.
- Reset mid-frame abandons the frame. The partial byte is never pushed.
- Read latency: `d_out` updates on the clock edge where `cs&rd` is sampled. It is valid the following cycle and holds until the next read.
- A pop takes effect on that same edge. `rx_ready` and LEVEL reflect it the next cycle.
- Push latency: the byte is visible in `rx_ready` one cycle after the STOP sample tick.
- Input to sample delay: 2 cycles of synchronizer latency plus up to 1 tick of start-edge uncertainty.
- A full frame takes 10 bit times. At the defaults that is 160 ticks = 4320 clocks.

## Configuration
- `UART_RX_FIFO_EN` defined: circular FIFO of `FIFO_DEPTH` bytes with read/write pointers of width log2(FIFO_DEPTH) that wrap. The count runs 0..FIFO_DEPTH.
- Not defined: a single holding register, so the count is 0 or 1. A second byte arriving before a read sets `overrun` and is dropped.
- The register map and timing are identical in both builds.

## Structure
- Shared package/include `uart_rx_defs` holds:
  - register offsets (DATA/STATUS/LEVEL/CLEAR),
  - STATUS bit indices,
  - FSM state encodings,
  - oversample factor 16.
- Sub-module `uart_rx_fifo` holds the buffer: push, pop, full, empty, count, `dout` = head. The `UART_RX_FIFO_EN` switch lives inside it.
- The top of this block contains the synchronizer, tick generator, FSM and bus register logic.

## Test plan
- **Single byte:** drive 0xA5 at 115200 with 432-clock bits → `rx_ready` = 1, STATUS = 0x0001. Read 0x0 → 0x00A5. Afterwards LEVEL = 0 and `rx_ready` = 0.
- **Glitch rejection:** a 100-clock low pulse → no push, FSM back in IDLE. A following valid 0x3C is received correctly.
- **Framing error:** a 0x55 frame with stop bit 0 → STATUS = 0x0004, LEVEL = 0. Write 0x6 with 0x0002 → STATUS = 0x0000.
- **Overflow (FIFO build, depth 8):** send 0x01..0x09 without reading → LEVEL = 8, `overrun` = 1. Reads return 0x01..0x08 in order. Write 0x6 with 0x0001 → `overrun` cleared.
- **Simultaneous events:** with the buffer full, pop on the same cycle as a push → no overrun, count stays 8. W1C on the same cycle as a new framing error → `frame_err` remains 1.
- **Reset mid-frame:** assert `rst` one cycle during DATA bit 4 → all outputs 0. The next full frame 0xC3 is received correctly.
